ai_shot_controller: RTL and testbench

- Sequences the density engine for one AI turn.
- Latches the game FSM's fired map and live-ship mask and holds them stable on the engine inputs.
- Restarts the engine with a one-cycle local reset, waits its fixed compute time, then scans the 100 densities one per cycle.
- Returns the highest-density unfired cell to the game FSM over a valid/ready handshake.

---
 rtl/ai_shot_controller.sv | 200 ++++++++++++++++++++
 tb/tb_ai_shot_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ai_shot_controller.sv
// Sequences one AI turn: latch the board, restart the density engine, wait for it to settle,
// scan the 100 densities and hand the best unfired cell back to the game FSM.
//   state | meaning
//   IDLE  | ready for a request, engine held out of reset
//   KICK  | one-cycle engine restart, load wait timer
//   WAIT  | down-count until density is final
//   SCAN  | one cell per cycle, track highest unfired density
//   OUT   | result presented until shot_ready
module ai_shot_controller #(
    parameter int ENG_LATENCY = 320,
    parameter int CNT_W       = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [99:0]  fired_in,
    input  logic [4:0]   ships_in,
    output logic         eng_rst_n,
    output logic [99:0]  eng_fired,
    output logic [4:0]   eng_ships,
    input  logic [599:0] eng_density,
    output logic         shot_valid,
    input  logic         shot_ready,
    output logic [6:0]   shot_idx,
    output logic [3:0]   shot_x,
    output logic [3:0]   shot_y,
    output logic         shot_none,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KICK,
        S_WAIT,
        S_SCAN,
        S_OUT
    } state_t;

    state_t      state, state_d;
    logic        eng_rst_n_q, eng_rst_n_d;
    logic [99:0] fired_q, fired_d;
    logic [4:0]  ships_q, ships_d;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
    logic [6:0]  scan_idx, scan_idx_d;
    logic [5:0]  best_val, best_val_d;
    logic [6:0]  best_idx, best_idx_d;
    logic        found, found_d;
    logic        valid_q, valid_d;
    logic [6:0]  idx_q, idx_d;
    logic [3:0]  x_q, x_d;
    logic [3:0]  y_q, y_d;
    logic        none_q, none_d;

    logic [5:0]  cur_dens;
    logic        cur_fired;
    logic        take;
    logic [6:0]  final_idx;
    logic [3:0]  final_x;
    logic [3:0]  final_y;

    always_comb begin
        cur_dens  = '0;
        cur_fired = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (scan_idx == 7'(i)) begin
                cur_dens  = eng_density[6*i +: 6];
                cur_fired = fired_q[i];
            end
        end
    end

    // Strict compare keeps the first (lowest-index) cell on ties.
    assign take      = !cur_fired && (!found || (cur_dens > best_val));
    assign final_idx = take ? scan_idx : best_idx;

    always_comb begin
        final_x = '0;
        final_y = '0;
        for (int i = 0; i < 100; i++) begin
            if (final_idx == 7'(i)) begin
                final_x = 4'(i % 10);
                final_y = 4'(i / 10);
            end
        end
    end

    always_comb begin
        state_d     = state;
        eng_rst_n_d = 1'b1;
        fired_d     = fired_q;
        ships_d     = ships_q;
        wait_cnt_d  = wait_cnt;
        scan_idx_d  = scan_idx;
        best_val_d  = best_val;
        best_idx_d  = best_idx;
        found_d     = found;
        valid_d     = valid_q;
        idx_d       = idx_q;
        x_d         = x_q;
        y_d         = y_q;
        none_d      = none_q;

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    fired_d     = fired_in;
                    ships_d     = ships_in;
                    eng_rst_n_d = 1'b0;
                    state_d     = S_KICK;
                end
            end
            S_KICK: begin
                wait_cnt_d = CNT_W'(ENG_LATENCY - 1);
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    scan_idx_d = '0;
                    found_d    = 1'b0;
                    best_val_d = '0;
                    best_idx_d = '0;
                    state_d    = S_SCAN;
                end else begin
                    wait_cnt_d = wait_cnt - 1'b1;
                end
            end
            S_SCAN: begin
                if (take) begin
                    best_val_d = cur_dens;
                    best_idx_d = scan_idx;
                    found_d    = 1'b1;
                end
                if (scan_idx == 7'd99) begin
                    idx_d   = final_idx;
                    x_d     = final_x;
                    y_d     = final_y;
                    none_d  = !(found || take);
                    valid_d = 1'b1;
                    state_d = S_OUT;
                end else begin
                    scan_idx_d = scan_idx + 7'd1;
                end
            end
            S_OUT: begin
                if (shot_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            eng_rst_n_q <= 1'b0;
            fired_q     <= '0;
            ships_q     <= '0;
            wait_cnt    <= '0;
            scan_idx    <= '0;
            best_val    <= '0;
            best_idx    <= '0;
            found       <= 1'b0;
            valid_q     <= 1'b0;
            idx_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            none_q      <= 1'b0;
        end else begin
            state       <= state_d;
            eng_rst_n_q <= eng_rst_n_d;
            fired_q     <= fired_d;
            ships_q     <= ships_d;
            wait_cnt    <= wait_cnt_d;
            scan_idx    <= scan_idx_d;
            best_val    <= best_val_d;
            best_idx    <= best_idx_d;
            found       <= found_d;
            valid_q     <= valid_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            y_q         <= y_d;
            none_q      <= none_d;
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign eng_rst_n  = eng_rst_n_q;
    assign eng_fired  = fired_q;
    assign eng_ships  = ships_q;
    assign shot_valid = valid_q;
    assign shot_idx   = idx_q;
    assign shot_x     = x_q;
    assign shot_y     = y_q;
    assign shot_none  = none_q;

endmodule

// File: tb/tb_ai_shot_controller.sv
// Self-checking bench for ai_shot_controller: fixed vector table, hand-written corner
// sequences, and randomized boards checked against a max-then-first-index reference model.
module tb_ai_shot_controller;

    localparam int L = 320;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [99:0]  fired_in;
    logic [4:0]   ships_in;
    logic         eng_rst_n;
    logic [99:0]  eng_fired;
    logic [4:0]   eng_ships;
    logic [599:0] eng_density;
    logic         shot_valid;
    logic         shot_ready;
    logic [6:0]   shot_idx;
    logic [3:0]   shot_x;
    logic [3:0]   shot_y;
    logic         shot_none;
    logic         busy;

    int checks = 0;
    int errors = 0;

    ai_shot_controller #(.ENG_LATENCY(L), .CNT_W(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .fired_in(fired_in), .ships_in(ships_in),
        .eng_rst_n(eng_rst_n), .eng_fired(eng_fired), .eng_ships(eng_ships),
        .eng_density(eng_density),
        .shot_valid(shot_valid), .shot_ready(shot_ready),
        .shot_idx(shot_idx), .shot_x(shot_x), .shot_y(shot_y),
        .shot_none(shot_none), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [99:0]  fired;
        logic [4:0]   ships;
        logic [599:0] dens;
        logic [6:0]   exp_idx;
        logic         exp_none;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: highest density among unfired cells, then the first cell carrying it.
    function automatic void model(input logic [99:0] f, input logic [599:0] d,
                                  output logic [6:0] idx, output logic none);
        int mx = -1;
        for (int i = 0; i < 100; i++)
            if (!f[i] && int'(d[6*i +: 6]) > mx) mx = int'(d[6*i +: 6]);
        none = (mx < 0);
        idx  = '0;
        if (!none) begin
            for (int i = 99; i >= 0; i--)
                if (!f[i] && int'(d[6*i +: 6]) == mx) idx = 7'(i);
        end
    endfunction

    function automatic logic [599:0] pyramid();
        logic [599:0] d = '0;
        for (int i = 0; i < 100; i++) begin
            int x = i % 10;
            int y = i / 10;
            int dx = (x < 9 - x) ? x : 9 - x;
            int dy = (y < 9 - y) ? y : 9 - y;
            d[6*i +: 6] = 6'(dx + dy);
        end
        return d;
    endfunction

    task automatic run_shot(input logic [99:0] f, input logic [4:0] s, input logic [599:0] d,
                            input logic [6:0] ei, input logic en, input int hold, input bit disturb);
        int  k;
        bit  rst_glitch;
        bit  dist_ok;
        bit  stable;
        logic [6:0] ex_x, ex_y;
        ex_x = 7'(int'(ei) % 10);
        ex_y = 7'(int'(ei) / 10);
        @(negedge clk);
        fired_in    = f;
        ships_in    = s;
        eng_density = d;
        shot_ready  = (hold == 0);
        req_valid   = 1'b1;
        chk("req_ready_idle", 128'(req_ready), 128'(1));
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        chk("eng_rst_n_kick", 128'(eng_rst_n), 128'(0));
        chk("busy_kick", 128'(busy), 128'(1));
        chk("req_ready_kick", 128'(req_ready), 128'(0));
        rst_glitch = 0;
        dist_ok    = 1;
        while (!shot_valid && k < L + 200) begin
            @(negedge clk);
            k++;
            if (eng_rst_n !== 1'b1) rst_glitch = 1;
            if (disturb) begin
                if (k == 50) begin
                    req_valid = 1'b1;
                    fired_in  = ~f;
                end
                if (k == 54) req_valid = 1'b0;
                if (req_ready !== 1'b0) dist_ok = 0;
            end
            if (eng_fired !== f || eng_ships !== s) dist_ok = 0;
        end
        if (!shot_valid) begin
            errors++;
            $display("FAIL timeout: shot_valid not seen within %0d cycles", L + 200);
            return;
        end
        chk("latency", 128'(k + 1), 128'(L + 102));
        chk("eng_rst_n_single_pulse", 128'(rst_glitch), 128'(0));
        chk("eng_inputs_held", 128'(dist_ok), 128'(1));
        chk("shot_idx", 128'(shot_idx), 128'(ei));
        chk("shot_x", 128'(shot_x), 128'(ex_x));
        chk("shot_y", 128'(shot_y), 128'(ex_y));
        chk("shot_none", 128'(shot_none), 128'(en));
        if (hold > 0) begin
            stable = 1;
            repeat (hold) begin
                @(negedge clk);
                if (shot_valid !== 1'b1 || shot_idx !== ei || shot_none !== en ||
                    shot_x !== 4'(ex_x) || shot_y !== 4'(ex_y) || req_ready !== 1'b0) stable = 0;
            end
            chk("out_stable", 128'(stable), 128'(1));
            shot_ready = 1'b1;
        end
        @(negedge clk);
        chk("valid_drop", 128'(shot_valid), 128'(0));
        chk("req_ready_after", 128'(req_ready), 128'(1));
        chk("busy_after", 128'(busy), 128'(0));
        fired_in = '0;
    endtask

    initial begin
        logic [599:0] d;
        logic [99:0]  f;
        logic [4:0]   s;
        logic [6:0]   mi;
        logic         mn;
        int           k;

        rst_n = 1'b0; req_valid = 1'b0; shot_ready = 1'b0;
        fired_in = '0; ships_in = '0; eng_density = '0;

        vecs[0] = '{fired: '0, ships: 5'b11111, dens: pyramid(), exp_idx: 7'd44, exp_none: 1'b0};
        d = '0; d[6*37 +: 6] = 6'd12; d[6*73 +: 6] = 6'd12;
        vecs[1] = '{fired: '0, ships: 5'b00111, dens: d, exp_idx: 7'd37, exp_none: 1'b0};
        f = '0; f[37] = 1'b1;
        vecs[2] = '{fired: f, ships: 5'b00111, dens: d, exp_idx: 7'd73, exp_none: 1'b0};
        d = '0; d[6*73 +: 6] = 6'd63; f = '0; f[73] = 1'b1;
        vecs[3] = '{fired: f, ships: 5'b10000, dens: d, exp_idx: 7'd0, exp_none: 1'b0};
        vecs[4] = '{fired: '1, ships: 5'b11111, dens: pyramid(), exp_idx: 7'd0, exp_none: 1'b1};
        f = '0; f[4:0] = 5'b11111;
        vecs[5] = '{fired: f, ships: 5'b00000, dens: '0, exp_idx: 7'd5, exp_none: 1'b0};

        #12;
        chk("rst_req_ready", 128'(req_ready), 128'(1));
        chk("rst_eng_rst_n", 128'(eng_rst_n), 128'(0));
        chk("rst_shot_valid", 128'(shot_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("eng_rst_n_release", 128'(eng_rst_n), 128'(1));

        for (int i = 0; i < 6; i++) begin
            model(vecs[i].fired, vecs[i].dens, mi, mn);
            chk("model_vs_table", 128'({mn, mi}), 128'({vecs[i].exp_none, vecs[i].exp_idx}));
            run_shot(vecs[i].fired, vecs[i].ships, vecs[i].dens, vecs[i].exp_idx, vecs[i].exp_none,
                     (i == 4) ? 10 : 0, 1'b0);
        end

        // Request pulsed mid-WAIT with a changed board must be ignored.
        run_shot(vecs[2].fired, vecs[2].ships, vecs[2].dens, 7'd73, 1'b0, 0, 1'b1);

        // Reset mid-SCAN discards the pending result.
        @(negedge clk);
        fired_in = '0; ships_in = 5'b11111; eng_density = pyramid();
        shot_ready = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (k < L + 50) begin
            @(negedge clk);
            k++;
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_eng_rst_n", 128'(eng_rst_n), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_req_ready", 128'(req_ready), 128'(1));
        chk("mid_rst_outputs", 128'({shot_valid, shot_none, shot_idx, shot_x, shot_y}), 128'(0));
        chk("mid_rst_eng_fired", 128'({eng_fired, eng_ships}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_release", 128'(eng_rst_n), 128'(1));
        run_shot('0, 5'b11111, pyramid(), 7'd44, 1'b0, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            f = '0;
            d = '0;
            for (int i = 0; i < 100; i++) begin
                f[i] = ($urandom_range(0, 3) == 0) || (r == 7);
                d[6*i +: 6] = (r % 2 == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            end
            s = 5'($urandom);
            model(f, d, mi, mn);
            run_shot(f, s, d, mi, mn, (r == 3) ? 4 : 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
